fifo_wr_arb: RTL

- Round-robin arbiter that shares the single write port of the team's `fifo` between N_REQ requesters.
- Each requester presents a byte with a level request.
- The arbiter picks one requester and drives the fifo write handshake (en_w/data_i, wait ack_w). It then returns a one-cycle grant to the winner.
- Sits between producer blocks (e.g. protocol front-ends) and the fifo feeding uart_tx.

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/fifo_wr_arb_rr_pick.sv | 33 +++
 rtl/fifo_wr_arb.sv | 97 +++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the fifo write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } arb_state_e;

  // Index width for a requester count; never below one bit.
  function automatic int idx_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // Timeout counter width: holds 0..TIMEOUT-1.
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Rotating-priority search: first set request at or after ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  always_comb begin
    int               j;
    logic [IDX_W-1:0] j_idx;
    valid  = 1'b0;
    winner = '0;
    j      = 0;
    j_idx  = '0;
    // Walk from the farthest offset down so the closest hit to ptr wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      j_idx = IDX_W'(j);
      if (req[j_idx]) begin
        valid  = 1'b1;
        winner = j_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing the fifo write port between N_REQ requesters.
//
// state | meaning
// IDLE  | no write in flight; arbitrate when any req and fifo not full
// WRITE | en_w held with latched byte; wait ack_w or timeout
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DW-1:0]        wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [DW-1:0]              fifo_data_i,
  output logic                       fifo_en_w,
  input  logic                       fifo_ack_w,
  input  logic                       fifo_full,
  output logic                       busy,
  output logic                       err_timeout,
  output logic [$clog2(N_REQ)-1:0]   last_idx
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] GNT_ONE  = N_REQ'(1);

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] ptr_after;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // Winner moves to the back of the queue whether it was granted or aborted.
  assign ptr_after = (last_idx == IDX_LAST) ? '0 : last_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      gnt         <= '0;
      fifo_en_w   <= 1'b0;
      fifo_data_i <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      last_idx    <= '0;
      ptr         <= '0;
      cnt         <= '0;
    end else begin
      gnt         <= '0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid && !fifo_full) begin
            fifo_data_i <= wdata[pick_idx*DW +: DW];
            fifo_en_w   <= 1'b1;
            busy        <= 1'b1;
            last_idx    <= pick_idx;
            cnt         <= '0;
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (fifo_ack_w) begin
            fifo_en_w <= 1'b0;
            busy      <= 1'b0;
            gnt       <= GNT_ONE << last_idx;
            ptr       <= ptr_after;
            state     <= IDLE;
          end else if (cnt == CNT_LAST) begin
            fifo_en_w   <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
            ptr         <= ptr_after;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
